// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: default sizes, tag/pointer width
// helpers, the "no producer" tag constructor and the entry record.
package rob_pkg;

  localparam int unsigned ROB_DEPTH  = 16;
  localparam int unsigned ROB_DATA_W = 32;
  localparam int unsigned ROB_REG_W  = 5;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // One extra bit so the counter can hold DEPTH and tags can encode TAG_FREE.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned tag_free(input int unsigned depth);
    return depth;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic                  ready;
    logic [ROB_REG_W-1:0]  rd;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_tag_lookup.sv
// Combinational operand lookup into the ROB entry array.
// Optional same-cycle CDB forwarding is enabled by defining ROB_CDB_BYPASS_EN.
module rob_tag_lookup
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned DATA_W = ROB_DATA_W,
  parameter int unsigned TAG_W  = cnt_w(DEPTH)
) (
  input  logic [TAG_W-1:0]              tag_i,
  input  logic [DEPTH-1:0]              valid_i,
  input  logic [DEPTH-1:0]              ready_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]  data_i,
  input  logic                          cdb_valid_i,
  input  logic [TAG_W-1:0]              cdb_tag_i,
  input  logic [DATA_W-1:0]             cdb_data_i,
  output logic                          ready_o,
  output logic [DATA_W-1:0]             data_o
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);

  logic             is_free;
  logic [PTR_W-1:0] idx;
  logic             bypass_hit;

  // Any tag with the MSB set names no producer; the value is architectural.
  assign is_free = tag_i[TAG_W-1];
  assign idx     = tag_i[PTR_W-1:0];

`ifdef ROB_CDB_BYPASS_EN
  assign bypass_hit = cdb_valid_i && (cdb_tag_i == tag_i) && !is_free && valid_i[idx];
`else
  logic unused_cdb;
  assign unused_cdb = ^{cdb_valid_i, cdb_tag_i, cdb_data_i};
  assign bypass_hit = 1'b0;
`endif

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ready_o = 1'b0;
    data_o  = '0;
    if (is_free) begin
      ready_o = 1'b1;
    end else if (valid_i[idx]) begin
      ready_o = ready_i[idx];
      data_o  = data_i[idx];
    end
    if (bypass_hit) begin
      ready_o = 1'b1;
      data_o  = cdb_data_i;
    end
  end

endmodule

// File: rtl/rob_param.sv
// Circular reorder buffer: in-order allocate, CDB writeback, in-order commit,
// two operand lookups and a flush. Define ROB_CDB_BYPASS_EN for CDB forwarding.
module rob_param
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned DATA_W = ROB_DATA_W,
  parameter int unsigned REG_W  = ROB_REG_W,
  parameter int unsigned TAG_W  = cnt_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc_valid,
  input  logic [REG_W-1:0]         alloc_rd,
  output logic                     alloc_ready,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [TAG_W-1:0]         lk_tag1,
  input  logic [TAG_W-1:0]         lk_tag2,
  output logic                     lk_ready1,
  output logic                     lk_ready2,
  output logic [DATA_W-1:0]        lk_data1,
  output logic [DATA_W-1:0]        lk_data2,
  input  logic                     cdb_valid,
  input  logic [TAG_W-1:0]         cdb_tag,
  input  logic [DATA_W-1:0]        cdb_data,
  output logic                     commit_valid,
  output logic [REG_W-1:0]         commit_rd,
  output logic [DATA_W-1:0]        commit_data,
  output logic [TAG_W-1:0]         commit_tag,
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [DEPTH-1:0]             valid_q, valid_d, ready_q, ready_d;
  logic [DEPTH-1:0][REG_W-1:0]  rd_q, rd_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic                         commit_valid_q, commit_valid_d;
  logic [REG_W-1:0]             commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0]            commit_data_q, commit_data_d;
  logic [TAG_W-1:0]             commit_tag_q, commit_tag_d;

  logic             alloc_fire, commit_fire, cdb_hit;
  logic [PTR_W-1:0] cdb_idx;

  // Full blocks allocation even when the head retires this cycle.
  assign alloc_ready = !rst && (count_q != CNT_W'(DEPTH));
  assign alloc_tag   = TAG_W'(tail_q);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = valid_q[head_q] && ready_q[head_q];
  assign cdb_idx     = cdb_tag[PTR_W-1:0];
  assign cdb_hit     = cdb_valid && !cdb_tag[TAG_W-1] && valid_q[cdb_idx];

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    valid_d        = valid_q;
    ready_d        = ready_q;
    rd_d           = rd_q;
    data_d         = data_q;
    commit_valid_d = commit_fire;
    commit_rd_d    = rd_q[head_q];
    commit_data_d  = data_q[head_q];
    commit_tag_d   = TAG_W'(head_q);

    if (flush) begin
      head_d         = '0;
      tail_d         = '0;
      count_d        = '0;
      valid_d        = '0;
      ready_d        = '0;
      commit_valid_d = 1'b0;
    end else begin
      if (cdb_hit) begin
        ready_d[cdb_idx] = 1'b1;
        data_d[cdb_idx]  = cdb_data;
      end
      if (commit_fire) begin
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + PTR_W'(1);
      end
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        rd_d[tail_q]    = alloc_rd;
        data_d[tail_q]  = '0;
        tail_d          = tail_q + PTR_W'(1);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      ready_q        <= '0;
      commit_valid_q <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      commit_valid_q <= commit_valid_d;
    end
  end

  // NOTE: payload storage is not reset; valid bits and commit_valid qualify every use of it.
  always_ff @(posedge clk) begin
    rd_q          <= rd_d;
    data_q        <= data_d;
    commit_rd_q   <= commit_rd_d;
    commit_data_q <= commit_data_d;
    commit_tag_q  <= commit_tag_d;
  end

  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_data  = commit_data_q;
  assign commit_tag   = commit_tag_q;
  assign count        = count_q;

  rob_tag_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_lookup1 (
    .tag_i       (lk_tag1),
    .valid_i     (valid_q),
    .ready_i     (ready_q),
    .data_i      (data_q),
    .cdb_valid_i (cdb_valid),
    .cdb_tag_i   (cdb_tag),
    .cdb_data_i  (cdb_data),
    .ready_o     (lk_ready1),
    .data_o      (lk_data1)
  );

  rob_tag_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_lookup2 (
    .tag_i       (lk_tag2),
    .valid_i     (valid_q),
    .ready_i     (ready_q),
    .data_i      (data_q),
    .cdb_valid_i (cdb_valid),
    .cdb_tag_i   (cdb_tag),
    .cdb_data_i  (cdb_data),
    .ready_o     (lk_ready2),
    .data_o      (lk_data2)
  );

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised circular reorder buffer for the Tomasulo core.
- Decoder allocates entries in program order. The CDB marks entries ready with result data. The head retires in order to the register file.
- Two operand tag-lookup ports serve the decoder; a flush port clears all speculative state.
- Sits between Decoder (alloc/lookup), CDB (writeback) and RegFile (commit).

Parameters:
- DEPTH, 16, number of entries; power of two, at least 2.
- DATA_W, 32, result data width.
- REG_W, 5, architectural destination register index width.
- TAG_W, $clog2(DEPTH)+1, tag width. Low bits are the entry index; TAG_FREE = DEPTH (MSB set, rest 0) means "no producer".

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries
- alloc_valid  in  1  decoder requests an entry
- alloc_rd  in  REG_W  destination register of the new entry
- alloc_ready  out  1  entry available (count < DEPTH and not rst)
- alloc_tag  out  TAG_W  tag the next allocation receives (= tail index)
- lk_tag1, lk_tag2  in  TAG_W  operand tags to look up
- lk_ready1, lk_ready2  out  1  operand value available
- lk_data1, lk_data2  out  DATA_W  operand value
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  CDB tag
- cdb_data  in  DATA_W  CDB result
- commit_valid  out  1  one retired entry this cycle (registered)
- commit_rd  out  REG_W  retired destination register
- commit_data  out  DATA_W  retired value
- commit_tag  out  TAG_W  retired tag (lets the regfile clear its rename)
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

Behaviour:
- Entry fields: {valid, ready, rd, data}.
- Pointers head and tail are $clog2(DEPTH) bits, wrap modulo DEPTH. count is a separate counter wide enough to hold DEPTH.
- Reset (rst=1 at an edge): head=tail=count=0, all valid/ready bits cleared, commit_valid=0; alloc_ready=0 while rst is high. Overrides everything, including mid-operation.
- Allocate: fires when alloc_valid && alloc_ready at an edge. Writes {1,0,alloc_rd,0} at tail, then tail+1.
- Full: alloc_ready=0 when count==DEPTH, even if a commit occurs the same cycle (no same-cycle reuse).
- CDB: when cdb_valid, the tag MSB is 0 and the indexed entry is valid, set ready=1 and data=cdb_data at the edge.
- CDB ignored: TAG_FREE tags and tags of invalid entries are ignored silently.
- Commit: at an edge where the head entry is valid and ready, clear it, head+1, and register commit_valid=1 with rd/data/tag for exactly one cycle; otherwise commit_valid=0. At most one commit per cycle.
- Latency: CDB in cycle N, then the entry is ready after edge N, then commit at edge N+1, so commit_valid is high in cycle N+2.
- Simultaneous alloc + commit: count is unchanged. Alloc only gives count+1; commit only gives count-1.
- Alloc into a slot freed by a commit in the same cycle cannot occur (full rule above).
- Empty: no commit; head==tail with count==0.
- Lookup, combinational:
  - TAG_FREE: ready=1, data=0.
  - Valid entry: stored ready and data.
  - Invalid (non-free) entry: ready=0, data=0.
  - An entry committing this cycle still reports its stored data.
- Flush: at an edge, acts like reset of the entry state and pointers, with priority over alloc, CDB and commit in the same cycle. commit_valid=0 the next cycle.

Optional Feature:
- Macro ROB_CDB_BYPASS_EN.
- Defined: a lookup whose tag equals cdb_tag while cdb_valid=1 (tag not TAG_FREE, entry valid) returns ready=1 and data=cdb_data in the same cycle.
- Undefined: lookups see only stored state; the CDB value appears one cycle later.

Decomposition:
- Shared package rob_pkg holds:
  - DEPTH/DATA_W/REG_W defaults;
  - the TAG_FREE construction function;
  - the rob_entry_t struct {valid, ready, rd, data};
  - the pointer/count width helpers.
- One sub-module: rob_tag_lookup. It is a combinational single-port lookup (tag, entry array view, CDB inputs), instantiated twice, and contains the bypass logic.

Test Plan:
- Reset then 16 allocs (rd=1..16): tags 0..15, alloc_ready drops after the 16th, count=16; a 17th alloc_valid is ignored.
- Alloc tag 3, CDB tag 3 data 0xDEADBEEF in cycle N: lk_tag1=3 shows ready in N+1 (in N if bypass is defined); once tags 0..2 are retired, commit_valid for tag 3 carries data 0xDEADBEEF.
- Out-of-order CDB (tags 2,1,0 with data 0x22,0x11,0x00): commits occur in order 0,1,2 on consecutive cycles with the matching rd/data.
- Wrap-around: fill, retire 4, alloc 4 more: tags issued 0,1,2,3; total commits in order 4..15 then 0..3.
- Flush at count=7 with simultaneous alloc_valid and cdb_valid: count=0, no commit next cycle, alloc_tag=0, all lookups of non-free tags report ready=0.
- CDB with tag=TAG_FREE or tag of an empty entry: no state change; count and commit are unaffected.
